hrm_host_bridge: RTL and testbench
==================================

Name: hrm_host_bridge

Overview:
- Host-side controller for the HRM CPU's external interface.
- Receives a byte-stream command protocol from a host link (UART RX side, valid/ready) and returns response bytes to the host link (UART TX side, valid/ready).
- Drives the CPU's INBOX write port, OUTBOX read port, step/debug controls and dump select/position ports.
- Sits between the UART pair and the CPU top in the board-level design.

Parameters:
- POS_W, 5, width of dump FIFO position (FIFO depth = 2**POS_W).
- SEL_W, 3, width of dump component select.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset.
- rx_data  in  8  command byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx byte this cycle.
- tx_data  out  8  response byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host link accepts tx byte.
- cpu_in_data  out  8  byte pushed to INBOX.
- cpu_in_wr  out  1  INBOX write strobe.
- cpu_in_full  in  1  INBOX full.
- cpu_out_data  in  8  OUTBOX head byte; valid while cpu_out_empty=0.
- cpu_out_rd  out  1  OUTBOX pop strobe.
- cpu_out_empty  in  1  OUTBOX empty.
- cpu_nxtInstr  out  1  single-step strobe.
- cpu_debug  out  1  debug (step) mode level.
- cpu_dmp_chip_select  out  SEL_W  dump component.
- cpu_dmp_fifo_pos  out  POS_W  dump position.
- cpu_dmp_data  in  8  dump value (combinational from select/pos).
- cpu_dmp_valid  in  1  dump value valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset i_rst is synchronous, active-high.
- Reset values: state IDLE, rx_ready 1, tx_valid 0, tx_data 0, all strobes 0, cpu_debug 0, select 0, pos 0, busy 0.
- Reset mid-command discards any partial arguments and any pending tx byte.
- Transfer rules:
  - An rx byte transfers on rx_valid&&rx_ready. rx_ready=1 only in IDLE and GET_ARG.
  - A tx byte transfers on tx_valid&&tx_ready. tx_data/tx_valid are registered and held stable until the transfer.
- Strobes: cpu_in_wr, cpu_out_rd and cpu_nxtInstr are exactly one-cycle pulses, asserted from EXEC only.
- Opcodes (first byte) and arguments:
  - 0x10 PUSH d: 1 argument.
  - 0x11 POP: no argument.
  - 0x20 STEP: no argument.
  - 0x21 DBG b: 1 argument.
  - 0x30 PEEK s p: 2 arguments.
  - 0x31 DUMP s: 1 argument.
- Status codes: 0x00 OK, 0xE0 INBOX full, 0xE1 OUTBOX empty, 0xE2 invalid select/position, 0xE3 unknown opcode.
- Every command produces a status byte first. Unknown opcode produces 0xE3 only, with no argument bytes consumed.
- States: IDLE -> GET_ARG (while arguments remain) -> EXEC -> [SETTLE -> SCAN] -> SEND_STATUS -> [SEND_DATA | SEND_COUNT -> STREAM] -> IDLE.
- PUSH:
  - In EXEC, if cpu_in_full=0: cpu_in_data=d, cpu_in_wr pulse, status 0x00.
  - Otherwise no write, status 0xE0. The command is non-blocking.
- POP:
  - In EXEC, if cpu_out_empty=0: latch cpu_out_data, pulse cpu_out_rd the same cycle, status 0x00, then one data byte.
  - If empty: 0xE1 only.
- STEP: cpu_nxtInstr pulse, then 0x00. The pulse is issued regardless of cpu_debug.
- DBG: cpu_debug <= b[0], then 0x00.
- Accepted selects: {0,1,2,4,5}. Others, including 3, return 0xE2.
- PEEK:
  - Set select=s, pos=p[POS_W-1:0].
  - SETTLE 1 cycle, then sample cpu_dmp_valid/cpu_dmp_data.
  - Valid: 0x00 followed by the data byte. Invalid: 0xE2 only.
- DUMP s:
  - Set select=s, pos=0.
  - SCAN: each cycle sample cpu_dmp_valid; if valid, count++ and pos++. Stop at the first invalid position or after position 2**POS_W-1. The count is POS_W+1 bits, range 0..32.
  - Then send 0x00, a count byte, and count data bytes for pos 0..count-1.
  - Each data byte is loaded one settle cycle after pos changes.
  - For PC/REG/INSTR the count is 32 (the same value repeated); this is accepted behaviour.
- Backpressure: tx_ready=0 stalls the FSM in its SEND_* state with no CPU-side side effects; pos and select are held.
- cpu_dmp_chip_select and cpu_dmp_fifo_pos retain their last values after a command completes.

Decomposition:
- Package hrm_host_pkg: opcode constants, status constants, component select constants (INBOX 0, OUTBOX 1, PC 2, RAM 3, REG 4, INSTR 5), FSM state enum.
- One sub-module, hrm_tx_slot: 1-entry registered tx holding buffer with load/busy and valid/ready output.

Test Plan:
- Reset then PUSH 0x10 0x2A with cpu_in_full=0 -> one-cycle cpu_in_wr with cpu_in_data=0x2A; tx 0x00.
- PUSH 0x10 0x07 with cpu_in_full=1 -> no cpu_in_wr; tx 0xE0.
- POP with cpu_out_empty=0, cpu_out_data=0x5C -> single cpu_out_rd pulse; tx 0x00, 0x5C. POP with empty -> tx 0xE1, no pulse.
- DUMP 0x31 0x00 with positions 0..2 valid (0x11, 0x22, 0x33) and position 3 invalid -> tx 0x00, 0x03, 0x11, 0x22, 0x33.
- PEEK 0x30 0x03 0x00 -> 0xE2. Opcode 0x99 -> 0xE3. DBG 0x21 0x01 then STEP 0x20 -> cpu_debug=1, one cpu_nxtInstr pulse; tx 0x00, 0x00.
- tx_ready held low 10 cycles during POP response, and i_rst asserted mid-DUMP stream -> tx_data stable while stalled; after reset tx_valid=0, IDLE, and the next command works normally.

Source files
------------

// File: rtl/hrm_host_pkg.sv
// Shared constants and types for the HRM host bridge: opcodes, status codes,
// dump component selects and the command FSM state encoding.
package hrm_host_pkg;

    localparam logic [7:0] OP_PUSH = 8'h10;
    localparam logic [7:0] OP_POP  = 8'h11;
    localparam logic [7:0] OP_STEP = 8'h20;
    localparam logic [7:0] OP_DBG  = 8'h21;
    localparam logic [7:0] OP_PEEK = 8'h30;
    localparam logic [7:0] OP_DUMP = 8'h31;

    localparam logic [7:0] ST_OK        = 8'h00;
    localparam logic [7:0] ST_IN_FULL   = 8'hE0;
    localparam logic [7:0] ST_OUT_EMPTY = 8'hE1;
    localparam logic [7:0] ST_BAD_SEL   = 8'hE2;
    localparam logic [7:0] ST_BAD_OP    = 8'hE3;

    localparam int SEL_INBOX  = 0;
    localparam int SEL_OUTBOX = 1;
    localparam int SEL_PC     = 2;
    localparam int SEL_RAM    = 3;
    localparam int SEL_REG    = 4;
    localparam int SEL_INSTR  = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ARG,
        S_EXEC,
        S_SETTLE,
        S_SCAN,
        S_SEND_STATUS,
        S_SEND_DATA,
        S_SEND_COUNT,
        S_STREAM
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_PUSH) || (op == OP_POP) || (op == OP_STEP) ||
               (op == OP_DBG) || (op == OP_PEEK) || (op == OP_DUMP);
    endfunction

    function automatic logic [1:0] op_args(input logic [7:0] op);
        case (op)
            OP_PUSH, OP_DBG, OP_DUMP: return 2'd1;
            OP_PEEK:                  return 2'd2;
            default:                  return 2'd0;
        endcase
    endfunction

    // RAM (3) is not dumpable through the bridge, so it is rejected with the rest.
    function automatic logic sel_ok(input logic [7:0] s);
        return (s == 8'(SEL_INBOX)) || (s == 8'(SEL_OUTBOX)) || (s == 8'(SEL_PC)) ||
               (s == 8'(SEL_REG)) || (s == 8'(SEL_INSTR));
    endfunction

endpackage

// File: rtl/hrm_host_bridge_tx_slot.sv
// One-entry registered holding buffer for the host tx link; data and valid
// stay stable from load until the host accepts the byte.
module hrm_tx_slot (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (load && !tx_valid) begin
            tx_data  <= load_data;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    assign busy = tx_valid;

endmodule

// File: rtl/hrm_host_bridge.sv
// Host-side command bridge for the HRM CPU: parses the host byte protocol,
// drives INBOX/OUTBOX/step/dump ports and returns status and data bytes.
module hrm_host_bridge
    import hrm_host_pkg::*;
#(
    parameter int POS_W = 5,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       cpu_in_data,
    output logic             cpu_in_wr,
    input  logic             cpu_in_full,
    input  logic [7:0]       cpu_out_data,
    output logic             cpu_out_rd,
    input  logic             cpu_out_empty,
    output logic             cpu_nxtInstr,
    output logic             cpu_debug,
    output logic [SEL_W-1:0] cpu_dmp_chip_select,
    output logic [POS_W-1:0] cpu_dmp_fifo_pos,
    input  logic [7:0]       cpu_dmp_data,
    input  logic             cpu_dmp_valid,
    output logic             busy
);

    localparam int               CNT_W    = POS_W + 1;
    localparam logic [POS_W-1:0] POS_LAST = '1;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [7:0]       opcode, arg0, status, data_byte;
    logic [POS_W-1:0] arg1, pos;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] count, idx;
    logic             arg_idx, debug, settled;
    logic             rx_fire, tx_fire, sel_good;
    logic             slot_busy, slot_load;
    logic [7:0]       slot_byte;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign sel_good = sel_ok(arg0);

    always_ff @(posedge clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rx_ready     = 1'b0;
        cpu_in_wr    = 1'b0;
        cpu_out_rd   = 1'b0;
        cpu_nxtInstr = 1'b0;
        slot_load    = 1'b0;
        slot_byte    = status;
        case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (!op_known(rx_data))            state_nxt = S_SEND_STATUS;
                    else if (op_args(rx_data) == 2'd0) state_nxt = S_EXEC;
                    else                               state_nxt = S_GET_ARG;
                end
            end
            S_GET_ARG: begin
                rx_ready = 1'b1;
                if (rx_valid && (arg_idx || op_args(opcode) == 2'd1)) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_PUSH: cpu_in_wr    = !cpu_in_full;
                    OP_POP:  cpu_out_rd   = !cpu_out_empty;
                    OP_STEP: cpu_nxtInstr = 1'b1;
                    default: ;
                endcase
                if ((opcode == OP_PEEK || opcode == OP_DUMP) && sel_good) state_nxt = S_SETTLE;
                else                                                       state_nxt = S_SEND_STATUS;
            end
            S_SETTLE: state_nxt = (opcode == OP_DUMP) ? S_SCAN : S_SEND_STATUS;
            S_SCAN: begin
                if (!cpu_dmp_valid || pos == POS_LAST) state_nxt = S_SEND_STATUS;
            end
            S_SEND_STATUS: begin
                slot_load = !slot_busy;
                if (tx_fire) begin
                    if (status != ST_OK)                          state_nxt = S_IDLE;
                    else if (opcode == OP_POP || opcode == OP_PEEK) state_nxt = S_SEND_DATA;
                    else if (opcode == OP_DUMP)                   state_nxt = S_SEND_COUNT;
                    else                                          state_nxt = S_IDLE;
                end
            end
            S_SEND_DATA: begin
                slot_byte = data_byte;
                slot_load = !slot_busy;
                if (tx_fire) state_nxt = S_IDLE;
            end
            S_SEND_COUNT: begin
                slot_byte = 8'(count);
                slot_load = !slot_busy;
                if (tx_fire) state_nxt = (count == '0) ? S_IDLE : S_STREAM;
            end
            S_STREAM: begin
                // Data is loaded only after one settle cycle at the new position.
                slot_byte = cpu_dmp_data;
                slot_load = settled && !slot_busy;
                if (tx_fire && idx == count - CNT_ONE) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            opcode    <= 8'h00;
            arg0      <= 8'h00;
            arg1      <= '0;
            arg_idx   <= 1'b0;
            status    <= ST_OK;
            data_byte <= 8'h00;
            sel       <= '0;
            pos       <= '0;
            debug     <= 1'b0;
            count     <= '0;
            idx       <= '0;
            settled   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        opcode  <= rx_data;
                        arg_idx <= 1'b0;
                        status  <= op_known(rx_data) ? ST_OK : ST_BAD_OP;
                    end
                end
                S_GET_ARG: begin
                    if (rx_fire) begin
                        if (!arg_idx) arg0 <= rx_data;
                        else          arg1 <= rx_data[POS_W-1:0];
                        arg_idx <= 1'b1;
                    end
                end
                S_EXEC: begin
                    count <= '0;
                    case (opcode)
                        OP_PUSH: status <= cpu_in_full ? ST_IN_FULL : ST_OK;
                        OP_POP: begin
                            status    <= cpu_out_empty ? ST_OUT_EMPTY : ST_OK;
                            data_byte <= cpu_out_data;
                        end
                        OP_DBG: debug <= arg0[0];
                        OP_PEEK, OP_DUMP: begin
                            sel    <= arg0[SEL_W-1:0];
                            pos    <= (opcode == OP_PEEK) ? arg1 : '0;
                            status <= sel_good ? ST_OK : ST_BAD_SEL;
                        end
                        default: ;
                    endcase
                end
                S_SETTLE: begin
                    if (opcode == OP_PEEK) begin
                        if (cpu_dmp_valid) data_byte <= cpu_dmp_data;
                        else               status    <= ST_BAD_SEL;
                    end
                end
                S_SCAN: begin
                    if (cpu_dmp_valid) begin
                        count <= count + CNT_ONE;
                        if (pos != POS_LAST) pos <= pos + POS_ONE;
                    end
                end
                S_SEND_COUNT: begin
                    if (tx_fire) begin
                        pos     <= '0;
                        idx     <= '0;
                        settled <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (!settled) settled <= 1'b1;
                    if (tx_fire && idx != count - CNT_ONE) begin
                        idx     <= idx + CNT_ONE;
                        pos     <= pos + POS_ONE;
                        settled <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    hrm_tx_slot u_tx_slot (
        .clk       (clk),
        .i_rst     (i_rst),
        .load      (slot_load),
        .load_data (slot_byte),
        .busy      (slot_busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    assign cpu_in_data         = arg0;
    assign cpu_debug           = debug;
    assign cpu_dmp_chip_select = sel;
    assign cpu_dmp_fifo_pos    = pos;
    assign busy                = (state != S_IDLE);

endmodule

// File: tb/tb_hrm_host_bridge.sv
// Directed self-checking bench for hrm_host_bridge: drives host command bytes,
// models the CPU dump/INBOX/OUTBOX side and checks responses and strobes.
module tb_hrm_host_bridge;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] cpu_in_data;
    logic       cpu_in_wr;
    logic       cpu_in_full;
    logic [7:0] cpu_out_data;
    logic       cpu_out_rd;
    logic       cpu_out_empty;
    logic       cpu_nxtInstr;
    logic       cpu_debug;
    logic [2:0] cpu_dmp_chip_select;
    logic [4:0] cpu_dmp_fifo_pos;
    logic [7:0] cpu_dmp_data;
    logic       cpu_dmp_valid;
    logic       busy;

    logic [7:0]  dmp_mem [32];
    logic [31:0] dmp_vld;

    int checks = 0;
    int failures = 0;
    int in_wr_cnt = 0, out_rd_cnt = 0, nxt_cnt = 0, dbl_pulse = 0;
    logic [7:0] last_in_data = 8'h00;
    logic prev_wr = 1'b0, prev_rd = 1'b0, prev_nxt = 1'b0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    assign cpu_dmp_valid = dmp_vld[cpu_dmp_fifo_pos];
    assign cpu_dmp_data  = dmp_mem[cpu_dmp_fifo_pos];

    hrm_host_bridge #(.POS_W(5), .SEL_W(3)) dut (
        .clk                 (clk),
        .i_rst               (i_rst),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .cpu_in_data         (cpu_in_data),
        .cpu_in_wr           (cpu_in_wr),
        .cpu_in_full         (cpu_in_full),
        .cpu_out_data        (cpu_out_data),
        .cpu_out_rd          (cpu_out_rd),
        .cpu_out_empty       (cpu_out_empty),
        .cpu_nxtInstr        (cpu_nxtInstr),
        .cpu_debug           (cpu_debug),
        .cpu_dmp_chip_select (cpu_dmp_chip_select),
        .cpu_dmp_fifo_pos    (cpu_dmp_fifo_pos),
        .cpu_dmp_data        (cpu_dmp_data),
        .cpu_dmp_valid       (cpu_dmp_valid),
        .busy                (busy)
    );

    always @(posedge clk) begin
        if (cpu_in_wr) begin
            in_wr_cnt++;
            last_in_data = cpu_in_data;
        end
        if (cpu_out_rd) out_rd_cnt++;
        if (cpu_nxtInstr) nxt_cnt++;
        if ((cpu_in_wr && prev_wr) || (cpu_out_rd && prev_rd) || (cpu_nxtInstr && prev_nxt))
            dbl_pulse++;
        prev_wr  = cpu_in_wr;
        prev_rd  = cpu_out_rd;
        prev_nxt = cpu_nxtInstr;
        if (tx_valid && tx_ready && !i_rst) tx_q.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("rx_accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int t = 0;
        while ((tx_q.size() < n || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 3000), 32'd1);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        if (tx_q.size() == 0) b = 8'hxx;
        else                  b = tx_q.pop_front();
        chk(tag, {24'h0, b}, {24'h0, exp});
    endtask

    initial begin
        logic [7:0] held;
        logic       stable;
        int         t;
        i_rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        cpu_in_full = 1'b0;
        cpu_out_empty = 1'b1;
        cpu_out_data = 8'h00;
        dmp_vld = 32'h0;
        for (int i = 0; i < 32; i++) dmp_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        chk("rst_rx_ready", {31'h0, rx_ready}, 32'd1);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h00);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_debug", {31'h0, cpu_debug}, 32'd0);
        chk("rst_sel_pos", {24'h0, cpu_dmp_chip_select, cpu_dmp_fifo_pos}, 32'h0);
        chk("rst_strobes", {29'h0, cpu_in_wr, cpu_out_rd, cpu_nxtInstr}, 32'h0);

        // PUSH with room
        send_byte(8'h10); send_byte(8'h2A);
        wait_tx(1, "push_ok");
        expect_tx("push_ok_status", 8'h00);
        chk("push_ok_wr_cnt", 32'(in_wr_cnt), 32'd1);
        chk("push_ok_wr_data", {24'h0, last_in_data}, 32'h2A);

        // PUSH with INBOX full
        cpu_in_full = 1'b1;
        send_byte(8'h10); send_byte(8'h07);
        wait_tx(1, "push_full");
        expect_tx("push_full_status", 8'hE0);
        chk("push_full_no_wr", 32'(in_wr_cnt), 32'd1);
        cpu_in_full = 1'b0;

        // POP with data, then POP empty
        cpu_out_empty = 1'b0; cpu_out_data = 8'h5C;
        send_byte(8'h11);
        wait_tx(2, "pop_ok");
        expect_tx("pop_ok_status", 8'h00);
        expect_tx("pop_ok_data", 8'h5C);
        chk("pop_ok_rd_cnt", 32'(out_rd_cnt), 32'd1);
        cpu_out_empty = 1'b1;
        send_byte(8'h11);
        wait_tx(1, "pop_empty");
        expect_tx("pop_empty_status", 8'hE1);
        chk("pop_empty_no_rd", 32'(out_rd_cnt), 32'd1);

        // DUMP select 0 with three valid positions
        dmp_mem[0] = 8'h11; dmp_mem[1] = 8'h22; dmp_mem[2] = 8'h33; dmp_mem[3] = 8'h44;
        dmp_vld = 32'h0000_0007;
        send_byte(8'h31); send_byte(8'h00);
        wait_tx(5, "dump3");
        expect_tx("dump3_status", 8'h00);
        expect_tx("dump3_count", 8'h03);
        expect_tx("dump3_d0", 8'h11);
        expect_tx("dump3_d1", 8'h22);
        expect_tx("dump3_d2", 8'h33);
        chk("dump3_extra", 32'(tx_q.size()), 32'd0);

        // PEEK valid select 4 pos 1, then PEEK select 3 rejected
        send_byte(8'h30); send_byte(8'h04); send_byte(8'h01);
        wait_tx(2, "peek_ok");
        expect_tx("peek_ok_status", 8'h00);
        expect_tx("peek_ok_data", 8'h22);
        chk("peek_retain_sel_pos", {24'h0, cpu_dmp_chip_select, cpu_dmp_fifo_pos}, {24'h0, 3'd4, 5'd1});
        send_byte(8'h30); send_byte(8'h03); send_byte(8'h00);
        wait_tx(1, "peek_bad");
        expect_tx("peek_bad_status", 8'hE2);
        chk("peek_bad_extra", 32'(tx_q.size()), 32'd0);

        // Unknown opcode
        send_byte(8'h99);
        wait_tx(1, "bad_op");
        expect_tx("bad_op_status", 8'hE3);
        chk("bad_op_extra", 32'(tx_q.size()), 32'd0);

        // DBG then STEP
        send_byte(8'h21); send_byte(8'h01);
        wait_tx(1, "dbg");
        expect_tx("dbg_status", 8'h00);
        chk("dbg_level", {31'h0, cpu_debug}, 32'd1);
        send_byte(8'h20);
        wait_tx(1, "step");
        expect_tx("step_status", 8'h00);
        chk("step_pulse_cnt", 32'(nxt_cnt), 32'd1);

        // Backpressure during POP response
        tx_ready = 1'b0;
        cpu_out_empty = 1'b0; cpu_out_data = 8'h6D;
        send_byte(8'h11);
        t = 0;
        while (!tx_valid && t < 100) begin @(negedge clk); t++; end
        chk("stall_valid_seen", 32'(t < 100), 32'd1);
        held = tx_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
        end
        chk("stall_stable", {31'h0, stable}, 32'd1);
        chk("stall_data", {24'h0, tx_data}, 32'h00);
        chk("stall_rd_cnt", 32'(out_rd_cnt), 32'd2);
        cpu_out_empty = 1'b1;
        tx_ready = 1'b1;
        wait_tx(2, "stall_pop");
        expect_tx("stall_pop_status", 8'h00);
        expect_tx("stall_pop_data", 8'h6D);

        // Full 32-entry DUMP, reset mid-stream
        for (int i = 0; i < 32; i++) dmp_mem[i] = 8'(8'h40 + i);
        dmp_vld = 32'hFFFF_FFFF;
        send_byte(8'h31); send_byte(8'h01);
        t = 0;
        while (tx_q.size() < 5 && t < 500) begin @(negedge clk); t++; end
        chk("dump32_progress", 32'(t < 500), 32'd1);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        expect_tx("dump32_status", 8'h00);
        expect_tx("dump32_count", 8'h20);
        expect_tx("dump32_d0", 8'h40);
        chk("midrst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_rx_ready", {31'h0, rx_ready}, 32'd1);
        chk("midrst_debug", {31'h0, cpu_debug}, 32'd0);
        tx_q.delete();

        send_byte(8'h10); send_byte(8'h55);
        wait_tx(1, "post_rst_push");
        expect_tx("post_rst_push_status", 8'h00);
        chk("post_rst_wr_cnt", 32'(in_wr_cnt), 32'd2);
        chk("post_rst_wr_data", {24'h0, last_in_data}, 32'h55);
        chk("no_double_pulse", 32'(dbl_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
